// File: rtl/mul_arb_pkg.sv
// Shared widths and FSM state type for the arbitrated shared multiplier.
package mul_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned PROD_W  = 8;

  typedef enum logic [1:0] {
    SLEEP = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin grant; the pointer moves just past the last winner.
// Build option MUL_ARB_PRIO_EN: requester 0 always wins, 1..3 rotate among themselves.
module rr_arb4
  import mul_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
`ifdef MUL_ARB_PRIO_EN
    if (en && req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + ID_W'(k);
`ifdef MUL_ARB_PRIO_EN
      if (en && !found && (idx != '0) && req[idx]) begin
`else
      if (en && !found && req[idx]) begin
`endif
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

  // Pointer only moves on a grant; a priority win by requester 0 leaves the 1..3 rotation alone.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
`ifdef MUL_ARB_PRIO_EN
    end else if (found && (gnt_id != '0)) begin
`else
    end else if (found) begin
`endif
      ptr <= gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shared 4x4 multiplier arbitrated among four requesters, with a SLEEP/WAKE/RUN power FSM.
// Build option MUL_ARB_PRIO_EN (in rr_arb4) gives requester 0 absolute priority.
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int unsigned IDLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_rdy,
  output logic                    dout_en,
  output logic [PROD_W-1:0]       dout,
  output logic [ID_W-1:0]         dout_id,
  output logic                    mul_gate_en,
  output logic                    sleep
);

  state_e              state;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                s1_vld;
  logic [OP_W-1:0]     s1_a;
  logic [OP_W-1:0]     s1_b;
  logic [ID_W-1:0]     s1_id;
  logic                s2_vld;
  logic [PROD_W-1:0]   s2_prod;
  logic [ID_W-1:0]     s2_id;
  logic [7:0]          idle_cnt;
  logic                idle_now;
  logic                idle_exp;

  rr_arb4 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state == RUN),
    .req    (req_vld),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_rdy     = gnt;
  assign mul_gate_en = (state != SLEEP);
  assign sleep       = (state == SLEEP);
  assign dout_en     = s2_vld;
  assign dout        = s2_prod;
  assign dout_id     = s2_id;

  assign idle_now = (state == RUN) && (req_vld == '0) && !s1_vld && !s2_vld;
  // Expiry fires on the cycle that completes the IDLE_CYC-th idle cycle, so SLEEP
  // starts exactly IDLE_CYC cycles after the pipeline drains; any request blocks it.
  assign idle_exp = idle_now && (idle_cnt >= 8'(IDLE_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= SLEEP;
      idle_cnt <= '0;
    end else begin
      case (state)
        SLEEP: begin
          idle_cnt <= '0;
          if (req_vld != '0) state <= WAKE;
        end
        WAKE: begin
          idle_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (idle_exp) begin
            state    <= SLEEP;
            idle_cnt <= '0;
          end else if (idle_now) begin
            idle_cnt <= (idle_cnt == 8'(IDLE_CYC)) ? idle_cnt : idle_cnt + 8'd1;
          end else begin
            idle_cnt <= '0;
          end
        end
        default: begin
          state    <= SLEEP;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  // Operand registers only load on a grant so the multiplier inputs stay quiet otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_id   <= '0;
      s2_vld  <= 1'b0;
      s2_prod <= '0;
      s2_id   <= '0;
    end else begin
      s1_vld <= (gnt != '0);
      s2_vld <= s1_vld;
      if (gnt != '0) begin
        s1_a  <= req_a[gnt_id*OP_W +: OP_W];
        s1_b  <= req_b[gnt_id*OP_W +: OP_W];
        s1_id <= gnt_id;
      end
      if (s1_vld) begin
        s2_prod <= PROD_W'(s1_a) * PROD_W'(s1_b);
        s2_id   <= s1_id;
      end
    end
  end

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter: IDLE_CYC, default 8, idle cycles in RUN before entering SLEEP; legal range 1..255.
REQ-002 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 rstn  input  1  reset is synchronous and active-low.
REQ-004 req_vld  input  4  per-requester operand-pair valid, bit i = requester i.
REQ-005 req_a  input  16  operand A, requester i on bits [4i+3:4i], unsigned.
REQ-006 req_b  input  16  operand B, requester i on bits [4i+3:4i], unsigned.
REQ-007 req_rdy  output  4  one-hot or zero grant; transfer when req_vld[i] & req_rdy[i].
REQ-008 dout_en  output  1  product valid strobe, one cycle per transfer.
REQ-009 dout  output  8  unsigned product A*B.
REQ-010 dout_id  output  2  requester index of the current dout.
REQ-011 mul_gate_en  output  1  enable for the external clock gate and operand isolation of the shared multiplier.
REQ-012 sleep  output  1  high while the FSM is in SLEEP.

Function
REQ-013 The FSM SHALL have the states SLEEP, WAKE and RUN and SHALL enter SLEEP on reset.
REQ-014 SLEEP -> WAKE when any req_vld bit is high; WAKE -> RUN unconditionally after 1 cycle; RUN -> SLEEP when the idle counter reaches IDLE_CYC and req_vld == 0 in that cycle.
REQ-015 req_rdy SHALL be 0 in SLEEP and WAKE; in RUN at most one bit per cycle SHALL be high, and only for a requester with req_vld high.
REQ-016 Arbitration: 4-way round-robin; after a grant to i, priority order starts at (i+1) mod 4; the pointer SHALL hold when no grant occurs.
REQ-017 Pipeline: the grant cycle N captures the operands and ID into stage-1 registers; stage 2 registers the product at the end of N+1; dout_en/dout/dout_id SHALL be valid during cycle N+2, giving a fixed 2-cycle latency and throughput of 1 per cycle.
REQ-018 Stage-1 operand registers SHALL hold their value in cycles without a grant (operand isolation); dout and dout_id SHALL hold their last value while dout_en is low.
REQ-019 Product width is 8 bits; 15*15 = 225 SHALL never overflow.
REQ-020 Idle counter: increments in RUN when req_vld == 0 and both pipeline stages are empty; it saturates at IDLE_CYC; it clears on any req_vld or pipeline occupancy and when leaving RUN.
REQ-021 If a request and idle-counter expiry occur in the same cycle, the request SHALL win and the FSM SHALL stay in RUN.
REQ-022 mul_gate_en SHALL be high in WAKE and RUN and low in SLEEP; SLEEP SHALL only be entered with the pipeline empty.
REQ-023 A requester SHALL be allowed to drop req_vld without a transfer; no state is retained for it.

Reset
REQ-024 When rstn is low at a clock edge: state = SLEEP; req_rdy = 0; dout_en = 0; dout = 0; dout_id = 0; mul_gate_en = 0; sleep = 1; RR pointer = 0; idle counter = 0; pipeline valid bits = 0.
REQ-025 Reset mid-operation SHALL discard in-flight products, and no dout_en SHALL be produced for them.

Configuration
REQ-026 Macro MUL_ARB_PRIO_EN: when defined, requester 0 SHALL win whenever req_vld[0] is high and requesters 1..3 round-robin among themselves; when undefined, pure 4-way round-robin per REQ-016 applies.

Structure
REQ-027 Package mul_arb_pkg SHALL hold NUM_REQ=4, OP_W=4, ID_W=2, PROD_W=8 and the FSM state enum (SLEEP, WAKE, RUN).
REQ-028 Round-robin grant logic SHALL be a sub-module rr_arb4, which includes the MUL_ARB_PRIO_EN option; the FSM, pipeline and idle counter SHALL be in mul_share_arb.

Verification
REQ-029 Reset release, then req_vld=0001, a=3, b=5 -> WAKE for 1 cycle, grant in first RUN cycle, and 2 cycles later dout_en=1, dout=15, dout_id=0.
REQ-030 All four requesters valid continuously with a=i+1, b=15 -> grants 0,1,2,3,0,... with one dout per cycle: 15, 30, 45, 60 (without MUL_ARB_PRIO_EN).
REQ-031 With MUL_ARB_PRIO_EN and req_vld=1111 held -> requester 0 granted every cycle; after dropping bit 0, grants go 1,2,3,1,...
REQ-032 Single transfer then idle, IDLE_CYC=8 -> sleep=1 and mul_gate_en=0 exactly 8 cycles after the pipeline empties; a request in the expiry cycle keeps RUN.
REQ-033 rstn low while 2 products are in flight -> no dout_en after reset, all outputs at their reset values.
REQ-034 a=15, b=15 -> dout=225; a=0, b=9 -> dout=0.
